// File: rtl/apb_pkg.sv
// ============================================================================
// Module  : apb_pkg
// Brief   : Shared widths, FSM state type and address legality helper for
//           the APB slave register memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_slv_state_t;

    // Legal means: at or above the base, word-aligned, and inside the array.
    function automatic logic apb_addr_legal(
        input logic [APB_ADDR_W-1:0] addr,
        input logic [APB_ADDR_W-1:0] base,
        input int unsigned           depth
    );
        logic [APB_ADDR_W-1:0] off;
        off = addr - base;
        return (addr >= base)
            && ((off >> 2) < APB_ADDR_W'(depth))
            && (addr[1:0] == 2'b00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_byte_mem.sv
// ============================================================================
// Module  : apb_byte_mem
// Brief   : DEPTH x 32-bit word storage with byte-enable writes, an
//           asynchronous read port and a synchronous clear on reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_byte_mem
    import apb_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_waddr,
    input  logic [APB_DATA_W-1:0] i_wdata,
    input  logic [APB_STRB_W-1:0] i_wstrb,
    input  logic [IDX_W-1:0]      i_raddr,
    output logic [APB_DATA_W-1:0] o_rdata
);

    logic [APB_DATA_W-1:0] mem_q [DEPTH];
    logic [APB_DATA_W-1:0] wr_word_d;

    // Merge the strobed bytes into the current word content.
    always_comb begin
        wr_word_d = mem_q[i_waddr];
        for (int b = 0; b < APB_STRB_W; b++) begin
            if (i_wstrb[b]) begin
                wr_word_d[8*b +: 8] = i_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (i_we) begin
            mem_q[i_waddr] <= wr_word_d;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

`default_nettype wire

// File: rtl/apb_slave_mem.sv
// ============================================================================
// Module  : apb_slave_mem
// Brief   : APB slave register memory with programmable wait states and an
//           error response for illegal addresses. Wait states are built only
//           when APB_SLV_WAIT_EN is defined; otherwise PREADY rises in the
//           first access cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_slave_mem
    import apb_pkg::*;
#(
    parameter logic [APB_ADDR_W-1:0] ADDR_BASE   = 32'h0000_0000,
    parameter int                    DEPTH       = 64,
    parameter int                    WAIT_CYCLES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [APB_ADDR_W-1:0] PADDR,
    input  logic [APB_DATA_W-1:0] PWDATA,
    input  logic [APB_STRB_W-1:0] PSTRB,
    output logic                  PREADY,
    output logic [APB_DATA_W-1:0] PRDATA,
    output logic                  PSLVERR
);

    localparam int IDX_W = $clog2(DEPTH);

    apb_slv_state_t        state_q,   state_d;
    logic [IDX_W-1:0]      idx_q,     idx_d;
    logic                  write_q,   write_d;
    logic [APB_DATA_W-1:0] wdata_q,   wdata_d;
    logic [APB_STRB_W-1:0] strb_q,    strb_d;
    logic                  illegal_q, illegal_d;
    logic                  pready_q,  pready_d;
    logic [APB_DATA_W-1:0] prdata_q,  prdata_d;
    logic                  pslverr_q, pslverr_d;

    logic                  go_resp;
    logic                  mem_we;
    logic [APB_DATA_W-1:0] mem_rdata;

`ifdef APB_SLV_WAIT_EN
    logic [3:0]            cnt_q,     cnt_d;
`else
    logic                  unused_wait_cfg;
    assign unused_wait_cfg = (WAIT_CYCLES != 0);
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        illegal_d = illegal_q;
        pready_d  = 1'b0;
        prdata_d  = '0;
        pslverr_d = 1'b0;
        go_resp   = 1'b0;
        mem_we    = 1'b0;
`ifdef APB_SLV_WAIT_EN
        cnt_d     = cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                // An access phase with no preceding setup is ignored.
                if (PSEL && !PENABLE) begin
                    idx_d     = IDX_W'((PADDR - ADDR_BASE) >> 2);
                    write_d   = PWRITE;
                    wdata_d   = PWDATA;
                    strb_d    = PSTRB;
                    illegal_d = !apb_addr_legal(PADDR, ADDR_BASE, DEPTH);
`ifdef APB_SLV_WAIT_EN
                    cnt_d     = 4'd0;
                    if (WAIT_CYCLES == 0) begin
                        go_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
`else
                    go_resp   = 1'b1;
`endif
                end
            end
`ifdef APB_SLV_WAIT_EN
            WAIT: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (PENABLE) begin
                    if (cnt_q == 4'(WAIT_CYCLES - 1)) begin
                        go_resp = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
`endif
            RESP: begin
                mem_we  = write_q && !illegal_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered on entry to RESP so they are valid for
        // exactly the completing access cycle.
        if (go_resp) begin
            state_d   = RESP;
            pready_d  = 1'b1;
            pslverr_d = illegal_d;
            prdata_d  = (!illegal_d && !write_d) ? mem_rdata : '0;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            illegal_q <= 1'b0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
`ifdef APB_SLV_WAIT_EN
            cnt_q     <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            illegal_q <= illegal_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
`ifdef APB_SLV_WAIT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    apb_byte_mem #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk     (PCLK),
        .rst     (PRESET),
        .i_we    (mem_we),
        .i_waddr (idx_q),
        .i_wdata (wdata_q),
        .i_wstrb (strb_q),
        .i_raddr (idx_d),
        .o_rdata (mem_rdata)
    );

    assign PREADY  = pready_q;
    assign PRDATA  = prdata_q;
    assign PSLVERR = pslverr_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
// ============================================================================
// Module  : tb_apb_slave_mem
// Brief   : Self-checking bench for apb_slave_mem: directed scenarios plus
//           randomized transfers against a word-array reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_slave_mem;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 64;
    localparam int          WAITC = 2;
`ifdef APB_SLV_WAIT_EN
    localparam int          EXP_LAT = WAITC + 1;
`else
    localparam int          EXP_LAT = 1;
`endif

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model [DEPTH];

    always #5 PCLK = ~PCLK;

    apb_slave_mem #(
        .ADDR_BASE   (BASE),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PSTRB   (PSTRB),
        .PREADY  (PREADY),
        .PRDATA  (PRDATA),
        .PSLVERR (PSLVERR)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_legal(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) / 32'd4) < 32'(DEPTH)) && (a % 32'd4 == 32'd0);
    endfunction

    function automatic int ref_idx(input logic [31:0] a);
        return int'((a - BASE) / 32'd4);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    // One complete APB transfer; lat is the access cycle where PREADY was
    // seen (0 if never within the budget).
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int lat,
                        output logic [31:0] rd, output logic err);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d; PSTRB = s;
        lat = 0; rd = 32'h0; err = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge PCLK);
            PENABLE = 1'b1;
            PWDATA  = $urandom;
            if (PREADY === 1'b1) begin
                lat = n; rd = PRDATA; err = PSLVERR;
                break;
            end
        end
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic do_xfer(input string tag, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        int          lat;
        logic [31:0] rd;
        logic        err;
        bit          legal;
        logic [31:0] exp_rd;
        legal  = ref_legal(a);
        exp_rd = (!wr && legal) ? model[ref_idx(a)] : 32'h0;
        xfer(wr, a, d, s, lat, rd, err);
        check_val({tag, " latency"}, lat, EXP_LAT);
        check_val({tag, " pslverr"}, err, !legal);
        check_val({tag, " prdata"},  rd,  exp_rd);
        if (wr && legal) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) model[ref_idx(a)][8*b +: 8] = d[8*b +: 8];
        end
        check_val({tag, " pready after"},  PREADY,  1'b0);
        check_val({tag, " pslverr after"}, PSLVERR, 1'b0);
        check_val({tag, " prdata after"},  PRDATA,  32'h0);
    endtask

    task automatic read_expect(input string tag, input logic [31:0] a, input logic [31:0] exp);
        int          lat;
        logic [31:0] rd;
        logic        err;
        xfer(1'b0, a, 32'h0, 4'h0, lat, rd, err);
        check_val({tag, " latency"}, lat, EXP_LAT);
        check_val({tag, " data"},    rd,  exp);
    endtask

    initial begin
        int highs;
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 32'h0; PWDATA = 32'h0; PSTRB = 4'h0;
        clear_model();
        repeat (3) @(negedge PCLK);
        check_val("reset pready",  PREADY,  1'b0);
        check_val("reset prdata",  PRDATA,  32'h0);
        check_val("reset pslverr", PSLVERR, 1'b0);
        PRESET = 1'b0;

        do_xfer("wr12", 1'b1, 32'd12, 32'd11, 4'hF);
        read_expect("rd12", 32'd12, 32'd11);

        do_xfer("wr0 full", 1'b1, 32'd0, 32'hAABBCCDD, 4'hF);
        do_xfer("wr0 strb", 1'b1, 32'd0, 32'h11223344, 4'b0101);
        read_expect("rd0 merge", 32'd0, 32'hAA22CC44);
        do_xfer("wr0 nostrb", 1'b1, 32'd0, 32'hFFFFFFFF, 4'b0000);
        read_expect("rd0 noop", 32'd0, 32'hAA22CC44);

        do_xfer("rd oob", 1'b0, 32'd256, 32'h0, 4'hF);
        do_xfer("wr misaligned", 1'b1, 32'd13, 32'hDEADBEEF, 4'hF);
        read_expect("rd12 intact", 32'd12, 32'd11);

`ifdef APB_SLV_WAIT_EN
        // Drop PSEL during the first wait cycle.
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'd8; PWDATA = 32'h55; PSTRB = 4'hF;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
        highs = 0;
        repeat (5) begin
            @(negedge PCLK);
            if (PREADY === 1'b1) highs++;
        end
        check_val("abort no pready", highs, 0);
        read_expect("abort rd8", 32'd8, 32'h0);
`endif

        // Reset asserted in the first access cycle of a write.
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'd12; PWDATA = 32'h77; PSTRB = 4'hF;
        @(negedge PCLK);
        PENABLE = 1'b1; PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        check_val("midreset pready",  PREADY,  1'b0);
        check_val("midreset prdata",  PRDATA,  32'h0);
        check_val("midreset pslverr", PSLVERR, 1'b0);
        clear_model();
        read_expect("midreset rd12", 32'd12, 32'h0);
        read_expect("midreset rd0",  32'd0,  32'h0);

        for (int t = 0; t < 40; t++) begin
            int          sel;
            logic [31:0] a;
            logic [31:0] idx;
            sel = int'($urandom_range(0, 9));
            idx = 32'($urandom_range(0, DEPTH - 1));
            if (sel < 6)       a = BASE + idx * 32'd4;
            else if (sel == 6) a = BASE + idx * 32'd4 + 32'($urandom_range(1, 3));
            else if (sel == 7) a = BASE + 32'(DEPTH) * 32'd4 + idx * 32'd4;
            else               a = BASE + (idx % 32'd4) * 32'd4;
            do_xfer($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
